// File: rtl/team_08_wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states, master ids and
// the packed request bundle used for the slave-side mux.
package team_08_wb_arb_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic                 cyc;
        logic                 stb;
        logic                 we;
        logic [WB_AW-1:0]     adr;
        logic [WB_DW-1:0]     dat;
        logic [WB_DW/8-1:0]   sel;
    } wb_req_t;

endpackage

// File: rtl/team_08_wb_arbiter_if.sv
// Wishbone classic link between one master and one slave.
// The master modport omits err: slaves behind this arbiter never raise it.
interface team_08_wb_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            ack;
    logic            err;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/team_08_wb_arb_timeout.sv
// Stall watchdog: counts cycles where the slave is strobed but silent and
// reports a hit on the last allowed cycle, followed by a one-cycle error pulse.
module team_08_wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic stall,
    input  logic ack,
    output logic hit,
    output logic err
);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 256) ? 16 : 8;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65536");
    end

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || ack) begin
            count <= '0;
        end else if (stall) begin
            count <= count + CW'(1);
        end
    end

    assign hit = stall && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= hit;
        end
    end
endmodule

// File: rtl/team_08_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter, grant held while cyc is high.
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module team_08_wb_arbiter
    import team_08_wb_arb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    team_08_wb_arbiter_if.slave         m0,
    team_08_wb_arbiter_if.slave         m1,
    team_08_wb_arbiter_if.master        s,
    output logic [1:0]                  gnt_o
);
    if (AW > WB_AW || DW > WB_DW || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("unsupported AW/DW or TIMEOUT_CYCLES == 0");
    end

    arb_state_t state;
    logic       last;
    logic       req0, req1;
    logic       ack_ok;
    logic       tmo_hit;
    logic [1:0] blocked;
    wb_req_t    r0, r1, sel_req;

    assign r0 = '{cyc: m0.cyc, stb: m0.stb, we: m0.we, adr: WB_AW'(m0.adr),
                  dat: WB_DW'(m0.dat_w), sel: (WB_DW/8)'(m0.sel)};
    assign r1 = '{cyc: m1.cyc, stb: m1.stb, we: m1.we, adr: WB_AW'(m1.adr),
                  dat: WB_DW'(m1.dat_w), sel: (WB_DW/8)'(m1.sel)};

    always_comb begin
        sel_req = '0;
        unique case (state)
            GNT0:    sel_req = r0;
            GNT1:    sel_req = r1;
            default: sel_req = '0;
        endcase
    end

    assign s.cyc   = sel_req.cyc;
    assign s.stb   = sel_req.stb;
    assign s.we    = sel_req.we;
    assign s.adr   = sel_req.adr[AW-1:0];
    assign s.dat_w = sel_req.dat[DW-1:0];
    assign s.sel   = sel_req.sel[DW/8-1:0];

    // Acks without an active strobe are stray and must not reach a master.
    assign ack_ok   = s.ack & s.stb;
    assign m0.ack   = ack_ok & (state == GNT0);
    assign m1.ack   = ack_ok & (state == GNT1);
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;

    assign req0 = m0.cyc & m0.stb & ~blocked[0];
    assign req1 = m1.cyc & m1.stb & ~blocked[1];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            last  <= M1;
            gnt_o <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || last == M1)) begin
                        state <= GNT0;
                        last  <= M0;
                        gnt_o <= 2'b01;
                    end else if (req1) begin
                        state <= GNT1;
                        last  <= M1;
                        gnt_o <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0.cyc || tmo_hit) begin
                        state <= IDLE;
                        gnt_o <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1.cyc || tmo_hit) begin
                        state <= IDLE;
                        gnt_o <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_o <= 2'b00;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic tmo_err;

    team_08_wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .clear (state == IDLE),
        .stall (s.stb & ~s.ack),
        .ack   (ack_ok),
        .hit   (tmo_hit),
        .err   (tmo_err)
    );

    // A timed-out master stays out of arbitration until it drops cyc.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            blocked <= 2'b00;
        end else begin
            if (!m0.cyc) begin
                blocked[0] <= 1'b0;
            end else if (tmo_hit && state == GNT0) begin
                blocked[0] <= 1'b1;
            end
            if (!m1.cyc) begin
                blocked[1] <= 1'b0;
            end else if (tmo_hit && state == GNT1) begin
                blocked[1] <= 1'b1;
            end
        end
    end

    // The error lands in the IDLE cycle after abort; last still names the victim.
    assign m0.err = tmo_err & (last == M0);
    assign m1.err = tmo_err & (last == M1);
`else
    assign tmo_hit = 1'b0;
    assign blocked = 2'b00;
    assign m0.err  = 1'b0;
    assign m1.err  = 1'b0;
`endif
endmodule
